// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB LED driver.
// Colour codes are ordered {r,g,b}.
package rgb_pkg;

    typedef enum logic {IDLE, SHOW} state_t;

    typedef logic [2:0] colour_t;

    localparam colour_t RED   = 3'b100;
    localparam colour_t GREEN = 3'b010;
    localparam colour_t BLUE  = 3'b001;
    localparam colour_t NONE  = 3'b000;

    // True when exactly one colour flag is set.
    function automatic logic is_onehot(input colour_t c);
        return (c == RED) || (c == GREEN) || (c == BLUE);
    endfunction

endpackage

// File: rtl/rgb_pwm_gen.sv
// Free-running PWM counter with a live duty compare.
// pwm_on is combinational from the counter and the current duty value.
module rgb_pwm_gen #(
    parameter int unsigned DUTY_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_on
);

    logic [DUTY_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
        end
    end

    assign pwm_on = (pwm_cnt < duty);

endmodule

// File: rtl/rgb_led_driver.sv
// Captures a one-hot colour on a sample strobe and displays it on an RGB LED
// for a fixed hold time, PWM-dimmed and optionally blinking.
module rgb_led_driver
    import rgb_pkg::*;
#(
    parameter int unsigned DUTY_W      = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned BLINK_HALF  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              red,
    input  logic              green,
    input  logic              blue,
    input  logic              sample,
    input  logic [DUTY_W-1:0] duty,
    input  logic              blink_en,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b,
    output logic              busy,
    output logic              err
);

    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    state_t             state;
    colour_t            colour;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               pwm_on;

    colour_t in_colour;
    logic    valid;
    logic    invalid;

    assign in_colour = {red, green, blue};
    assign valid     = sample & is_onehot(in_colour);
    assign invalid   = sample & ~is_onehot(in_colour);

    rgb_pwm_gen #(
        .DUTY_W (DUTY_W)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .duty   (duty),
        .pwm_on (pwm_on)
    );

    // LEDs are driven from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            colour      <= NONE;
            hold_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            led_r       <= 1'b0;
            led_g       <= 1'b0;
            led_b       <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            err   <= invalid;
            led_r <= (state == SHOW) & colour[2] & pwm_on & blink_phase;
            led_g <= (state == SHOW) & colour[1] & pwm_on & blink_phase;
            led_b <= (state == SHOW) & colour[0] & pwm_on & blink_phase;

            case (state)
                IDLE: begin
                    hold_cnt    <= '0;
                    blink_cnt   <= '0;
                    blink_phase <= 1'b1;
                    if (valid) begin
                        state  <= SHOW;
                        colour <= in_colour;
                        busy   <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SHOW: begin
                    // A retrigger wins over the terminal-count exit.
                    if (valid) begin
                        colour      <= in_colour;
                        hold_cnt    <= '0;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b1;
                        busy        <= 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state       <= IDLE;
                        colour      <= NONE;
                        hold_cnt    <= '0;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                        busy     <= 1'b1;
                        if (blink_en) begin
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt   <= '0;
                                blink_phase <= ~blink_phase;
                            end else begin
                                blink_cnt <= blink_cnt + BLINK_W'(1);
                            end
                        end else begin
                            blink_cnt   <= '0;
                            blink_phase <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_led_driver.sv
// Bench for rgb_led_driver: directed scenarios plus randomized traffic,
// checked every cycle against a timer-based behavioural model.
module tb_rgb_led_driver;

    localparam int unsigned DUTY_W = 4;
    localparam int unsigned HOLD   = 16;
    localparam int unsigned BH     = 4;
    localparam int unsigned PER    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              red, green, blue, sample, blink_en;
    logic [DUTY_W-1:0] duty;
    logic              led_r, led_g, led_b, busy, err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    rgb_led_driver #(
        .DUTY_W      (DUTY_W),
        .HOLD_CYCLES (HOLD),
        .BLINK_HALF  (BH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .sample   (sample),
        .duty     (duty),
        .blink_en (blink_en),
        .led_r    (led_r),
        .led_g    (led_g),
        .led_b    (led_b),
        .busy     (busy),
        .err      (err)
    );

    // Model: display is a timer since the last valid capture; blink phase is
    // derived from how long blinking has been continuously enabled.
    bit         m_show = 1'b0;
    logic [2:0] m_col  = 3'b000;
    int         m_age  = 0;
    int         m_bage = 0;
    int         m_pwm  = 0;
    logic [2:0] exp_led  = 3'b000;
    logic       exp_busy = 1'b0;
    logic       exp_err  = 1'b0;
    logic [2:0] m_in;
    bit         m_pon, m_ph;

    always @(posedge clk) begin
        m_in = {red, green, blue};
        if (rst) begin
            m_show = 1'b0; m_col = 3'b000; m_age = 0; m_bage = 0; m_pwm = 0;
            exp_led = 3'b000; exp_busy = 1'b0; exp_err = 1'b0;
        end else begin
            m_pon   = (m_pwm < int'(duty));
            m_ph    = ((m_bage / int'(BH)) % 2) == 0;
            exp_led = (m_show && m_pon && m_ph) ? m_col : 3'b000;
            exp_err = sample && ($countones(m_in) != 1);
            if (sample && $countones(m_in) == 1) begin
                m_show = 1'b1; m_col = m_in; m_age = 0; m_bage = 0;
            end else if (m_show) begin
                if (m_age == int'(HOLD) - 1) begin
                    m_show = 1'b0; m_col = 3'b000; m_age = 0; m_bage = 0;
                end else begin
                    m_age  = m_age + 1;
                    m_bage = blink_en ? m_bage + 1 : 0;
                end
            end
            exp_busy = m_show;
            m_pwm    = (m_pwm + 1) % int'(PER);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({led_r, led_g, led_b, busy, err} !== {exp_led, exp_busy, exp_err}) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t got rgb/busy/err=%b want=%b", $time,
                         {led_r, led_g, led_b, busy, err}, {exp_led, exp_busy, exp_err});
            end
        end
    end

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    int cnt_busy, cnt_r, cnt_g, cnt_b, cnt_err;

    // Called on a negedge; the strobe is seen by the next rising edge.
    task automatic pulse(input logic [2:0] c);
        {red, green, blue} = c;
        sample = 1'b1;
    endtask

    task automatic run_count(input int n);
        cnt_busy = 0; cnt_r = 0; cnt_g = 0; cnt_b = 0; cnt_err = 0;
        repeat (n) begin
            @(negedge clk);
            sample = 1'b0;
            cnt_busy += int'(busy);
            cnt_r    += int'(led_r);
            cnt_g    += int'(led_g);
            cnt_b    += int'(led_b);
            cnt_err  += int'(err);
        end
    endtask

    int tmp;
    int unsigned k;

    initial begin
        rst = 1'b1; sample = 1'b0; red = 1'b0; green = 1'b0; blue = 1'b0;
        duty = '0; blink_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_state", int'({led_r, led_g, led_b, busy, err}), 0);

        run_count(20);
        check("idle_busy", cnt_busy, 0);
        check("idle_err", cnt_err, 0);
        check("idle_leds", cnt_r + cnt_g + cnt_b, 0);

        duty = 4'd8; blink_en = 1'b0;
        pulse(3'b010);
        run_count(24);
        check("green_busy", cnt_busy, 16);
        check("green_led_g", cnt_g, 8);
        check("green_led_rb", cnt_r + cnt_b, 0);
        check("green_after", int'({led_r, led_g, led_b, busy}), 0);

        pulse(3'b110);
        run_count(4);
        check("inv110_err", cnt_err, 1);
        check("inv110_busy", cnt_busy, 0);
        pulse(3'b000);
        run_count(4);
        check("inv000_err", cnt_err, 1);
        check("inv000_busy_leds", cnt_busy + cnt_r + cnt_g + cnt_b, 0);

        duty = 4'd15; blink_en = 1'b1;
        pulse(3'b100);
        run_count(24);
        check("blink_busy", cnt_busy, 16);
        check("blink_r_window", int'(cnt_r == 7 || cnt_r == 8), 1);
        check("blink_gb", cnt_g + cnt_b, 0);

        duty = 4'd8; blink_en = 1'b0;
        pulse(3'b001);
        run_count(10);
        tmp = cnt_busy;
        pulse(3'b100);
        run_count(30);
        check("retrig_busy_total", tmp + cnt_busy, 26);
        check("retrig_red", cnt_r, 8);

        pulse(3'b010);
        run_count(16);
        tmp = cnt_busy;
        pulse(3'b001);
        run_count(20);
        check("term_retrig_busy", tmp + cnt_busy, 32);

        pulse(3'b100);
        run_count(5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_show", int'({led_r, led_g, led_b, busy, err}), 0);
        rst = 1'b0;

        duty = 4'd0;
        pulse(3'b010);
        run_count(24);
        check("duty0_busy", cnt_busy, 16);
        check("duty0_leds", cnt_r + cnt_g + cnt_b, 0);

        // Randomized traffic, checked every cycle by the compare process.
        repeat (3000) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 299) == 0);
            sample = ($urandom_range(0, 5) == 0);
            k = $urandom_range(0, 9);
            if (k < 7) {red, green, blue} = 3'(3'b001 << (k % 3));
            else       {red, green, blue} = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) duty = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
        end
        @(negedge clk);
        sample = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
